i2s_tx_mono: RTL

- Downstream audio output stage. Consumes filtered Q15 mono samples from the FIR (y_out / y_out_valid) and serialises them as I2S master to the DAC.
- Generates BCLK and LRCLK and sends the same sample in both left and right slots.
- Emits a one-cycle sample_req at each frame boundary; upstream uses it as its sample-rate tick.
- A one-deep holding buffer decouples FIR output timing from frame timing.

---
 rtl/i2s_tx_mono.sv | 104 ++++++++++
 1 files changed

// File: rtl/i2s_tx_mono.sv
// I2S master transmitter for a mono Q15 stream: the same sample goes out in both slots,
// with a one-deep holding buffer between the FIR output strobe and the frame load.
module i2s_tx_mono #(
    parameter int BCLK_HALF = 4,
    parameter int DATA_W    = 16,
    parameter int SLOT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] s_in,
    input  logic                     s_in_valid,
    output logic                     bclk,
    output logic                     lrclk,
    output logic                     sdata,
    output logic                     sample_req,
    output logic                     underrun,
    output logic                     overrun
);
    localparam int DIVW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BCW  = $clog2(2 * SLOT_BITS);
    localparam int IW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIVW-1:0] DIV_MAX  = DIVW'(BCLK_HALF - 1);
    localparam logic [BCW-1:0]  BIT_MAX  = BCW'(2 * SLOT_BITS - 1);
    localparam logic [BCW-1:0]  SLOT_L   = BCW'(SLOT_BITS);
    localparam logic [BCW-1:0]  DW_L     = BCW'(DATA_W);
    localparam bit              PAD_TAIL = (SLOT_BITS != DATA_W);

    logic [DIVW-1:0]          div_cnt;
    logic [BCW-1:0]           bit_cnt;
    logic [BCW-1:0]           bit_nxt;
    logic [BCW-1:0]           slot_pos;
    logic [IW-1:0]            bit_idx;
    logic signed [DATA_W-1:0] frame_q;
    logic signed [DATA_W-1:0] hold;
    logic                     hold_full;
    logic                     div_wrap;
    logic                     fall;
    logic                     load;
    logic                     sdata_nxt;

    // Slot position p is taken from the post-fall bit count, giving the one-BCLK I2S delay;
    // p=0 still carries the previous slot's last bit, read from frame_q before it reloads.
    always_comb begin
        div_wrap = (div_cnt == DIV_MAX);
        fall     = div_wrap && bclk;
        load     = fall && (bit_cnt == BIT_MAX);
        bit_nxt  = (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
        slot_pos = (bit_nxt >= SLOT_L) ? bit_nxt - SLOT_L : bit_nxt;
        bit_idx  = IW'(DW_L - slot_pos);
        if (slot_pos == '0)
            sdata_nxt = PAD_TAIL ? 1'b0 : frame_q[0];
        else if (slot_pos <= DW_L)
            sdata_nxt = frame_q[bit_idx];
        else
            sdata_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= '0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            frame_q    <= '0;
            hold_full  <= 1'b0;
        end else begin
            div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
            sample_req <= load;
            if (div_wrap)
                bclk <= ~bclk;
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrclk   <= (bit_nxt >= SLOT_L);
                sdata   <= sdata_nxt;
            end
            if (load) begin
                if (hold_full) begin
                    frame_q   <= hold;
                    hold_full <= s_in_valid;
                end else if (s_in_valid) begin
                    frame_q <= s_in;
                end else begin
                    underrun <= 1'b1;
                end
            end else if (s_in_valid) begin
                if (hold_full)
                    overrun <= 1'b1;
                hold_full <= 1'b1;
            end
        end
    end

    // Holding data needs no reset: hold_full alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (s_in_valid && !(load && !hold_full))
            hold <= s_in;
    end

endmodule
